// File: rtl/grey_pkg.sv
// Shared types and helpers for the Gray-code decoder.
//   grey_dec_state_t : decoder FSM states (IDLE = no previous code, TRACK)
//   gray2bin/bin2gray: reference conversions on up to MAX_W bits, zero-extended
package grey_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic {
    IDLE,
    TRACK
  } grey_dec_state_t;

  // Zero-extended inputs convert correctly: leading zeros add nothing to the
  // running XOR from the MSB downward.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey_to_bin_comb.sv
// Purely combinational W-bit Gray -> binary converter.
//   g_in  : Gray-coded input
//   b_out : binary equivalent (b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i])
module grey_to_bin_comb #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] g_in,
  output logic [W-1:0] b_out
);

  always_comb begin
    b_out[W-1] = g_in[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b_out[i] = b_out[i+1] ^ g_in[i];
    end
  end

endmodule

// File: rtl/grey_decoder.sv
// Gray-code stream decoder with step classification.
//   clk, rst            : rising-edge clock, async active-high reset
//   g_valid/g_ready/g_in: input Gray code stream
//   b_valid/b_ready/b_out: registered binary output beat (1-cycle latency)
//   dir, wrap, step_err : per-beat movement flags relative to previous code
//   err_cnt             : saturating count of step_err beats since reset
module grey_decoder
  import grey_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_valid,
  output logic             g_ready,
  input  logic [W-1:0]     g_in,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [W-1:0]     b_out,
  output logic             dir,
  output logic             wrap,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  grey_dec_state_t  state_q, state_d;
  logic [W-1:0]     prev_g_q, prev_g_d;
  logic [W-1:0]     b_out_q, b_out_d;
  logic             b_valid_q, b_valid_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [W-1:0]     b_cur;
  logic [W-1:0]     b_prev;
  logic [W-1:0]     diff;
  logic             one_bit;
  logic             accept;

  grey_to_bin_comb #(.W(W)) u_cur  (.g_in(g_in),     .b_out(b_cur));
  grey_to_bin_comb #(.W(W)) u_prev (.g_in(prev_g_q), .b_out(b_prev));

  // Single output register: it can take a new code whenever it is empty or
  // its current beat leaves this cycle.
  assign g_ready = ~b_valid_q | b_ready;
  assign accept  = g_valid & g_ready;

  // x & (x-1) clears the lowest set bit, so it is zero only for one-hot x.
  assign diff    = g_in ^ prev_g_q;
  assign one_bit = (diff != '0) && ((diff & (diff - W'(1))) == '0);

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned;
  // otherwise this always_comb would infer latches.
  always_comb begin
    state_d    = state_q;
    prev_g_d   = prev_g_q;
    b_out_d    = b_out_q;
    dir_d      = dir_q;
    wrap_d     = wrap_q;
    step_err_d = step_err_q;
    err_cnt_d  = err_cnt_q;
    b_valid_d  = b_valid_q;

    if (b_ready) b_valid_d = 1'b0;

    if (accept) begin
      b_valid_d  = 1'b1;
      b_out_d    = b_cur;
      prev_g_d   = g_in;
      state_d    = TRACK;
      dir_d      = 1'b0;
      wrap_d     = 1'b0;
      step_err_d = 1'b0;
      // In IDLE there is nothing to compare against, so the flags stay clear.
      if (state_q == TRACK) begin
        if (one_bit) begin
          dir_d  = (b_cur == b_prev + W'(1));
          wrap_d = ((b_prev == '1) && (b_cur == '0)) ||
                   ((b_prev == '0) && (b_cur == '1));
        end else if (diff != '0) begin
          step_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_g_q   <= '0;
      b_out_q    <= '0;
      b_valid_q  <= 1'b0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_g_q   <= prev_g_d;
      b_out_q    <= b_out_d;
      b_valid_q  <= b_valid_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign b_valid  = b_valid_q;
  assign b_out    = b_out_q;
  assign dir      = dir_q;
  assign wrap     = wrap_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_grey_decoder.sv
// Self-checking bench for grey_decoder: directed scenarios plus randomized
// traffic, compared each cycle against an arithmetic reference model. A second
// instance with ERR_W=2 exercises error-counter saturation on the same stimulus.
module tb_grey_decoder;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         g_valid = 1'b0;
  logic [W-1:0] g_in = '0;
  logic         b_ready = 1'b0;

  logic         g_ready, b_valid, dir, wrap, step_err;
  logic [W-1:0] b_out;
  logic [7:0]   err_cnt;

  logic         s_g_ready, s_b_valid, s_dir, s_wrap, s_step_err;
  logic [W-1:0] s_b_out;
  logic [1:0]   s_err_cnt;

  grey_decoder #(.W(W), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_ready(g_ready), .g_in(g_in),
    .b_valid(b_valid), .b_ready(b_ready), .b_out(b_out), .dir(dir),
    .wrap(wrap), .step_err(step_err), .err_cnt(err_cnt)
  );

  grey_decoder #(.W(W), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_ready(s_g_ready), .g_in(g_in),
    .b_valid(s_b_valid), .b_ready(b_ready), .b_out(s_b_out), .dir(s_dir),
    .wrap(s_wrap), .step_err(s_step_err), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (value visible on outputs after the last edge).
  bit     m_has_prev;
  int     m_prev_g;
  bit     m_valid;
  int     m_b, m_dir, m_wrap, m_err, m_cnt, m_cnt_sat;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b ^= (g >> s);
    return b & ((1 << W) - 1);
  endfunction

  function automatic int hamming(input int a, input int b);
    int x = a ^ b;
    int n = 0;
    for (int i = 0; i < W; i++) n += (x >> i) & 1;
    return n;
  endfunction

  task automatic model_reset();
    m_has_prev = 0; m_prev_g = 0; m_valid = 0;
    m_b = 0; m_dir = 0; m_wrap = 0; m_err = 0; m_cnt = 0; m_cnt_sat = 0;
  endtask

  task automatic check_outputs();
    check("b_valid",  int'(b_valid),  int'(m_valid));
    check("b_out",    int'(b_out),    m_b);
    check("dir",      int'(dir),      m_dir);
    check("wrap",     int'(wrap),     m_wrap);
    check("step_err", int'(step_err), m_err);
    check("err_cnt",  int'(err_cnt),  m_cnt);
    check("sat_err_cnt", int'(s_err_cnt), m_cnt_sat);
    check("sat_b_out",   int'(s_b_out),   m_b);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then let
  // the model take the rising edge.
  task automatic cycle(input bit gv, input int g, input bit br);
    bit rdy, acc;
    int b, pb, hd, mx;
    g_valid = gv;
    g_in    = g[W-1:0];
    b_ready = br;
    #1;
    rdy = !m_valid || br;
    acc = gv && rdy;
    check_outputs();
    check("g_ready", int'(g_ready), int'(rdy));
    check("sat_g_ready", int'(s_g_ready), int'(rdy));
    if (acc) begin
      mx = (1 << W) - 1;
      b  = g2b(g);
      m_dir = 0; m_wrap = 0; m_err = 0;
      if (m_has_prev) begin
        hd = hamming(g, m_prev_g);
        pb = g2b(m_prev_g);
        if (hd == 1) begin
          m_dir  = (b == ((pb + 1) % (mx + 1)));
          m_wrap = (pb == mx && b == 0) || (pb == 0 && b == mx);
        end else if (hd > 1) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt_sat < 3) m_cnt_sat++;
        end
      end
      m_b = b; m_prev_g = g; m_has_prev = 1; m_valid = 1;
    end else if (br) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    g_valid = 1'b0;
    #1;
    check("rst_b_valid", int'(b_valid), 0);
    check("rst_b_out",   int'(b_out), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_step_err", int'(step_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int codes[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset: ready with nothing pending.
    cycle(0, 0, 0);
    check("t1_g_ready", int'(g_ready), 1);

    // Full up-count through all codes, then the wrap back to zero.
    for (int i = 0; i < 8; i++) begin
      cycle(1, codes[i], 1);
      check("t2_b_out", int'(b_out), i);
      if (i > 0) check("t2_dir", int'(dir), 1);
    end
    cycle(1, 0, 1);
    check("t2_wrap", int'(wrap), 1);
    check("t2_dir_wrap", int'(dir), 1);

    // Downward wrap and a plain down step.
    cycle(1, 0, 1);
    cycle(1, 3'b100, 1);
    check("t3_b_out", int'(b_out), 7);
    check("t3_wrap", int'(wrap), 1);
    check("t3_dir", int'(dir), 0);
    cycle(1, 3'b101, 1);
    check("t3_b_out2", int'(b_out), 6);
    check("t3_wrap2", int'(wrap), 0);

    // Step errors and saturation of the narrow counter.
    do_reset();
    cycle(1, 3'b000, 1);
    cycle(1, 3'b011, 1);
    check("t4_b_out", int'(b_out), 2);
    check("t4_err", int'(step_err), 1);
    check("t4_cnt", int'(err_cnt), 1);
    cycle(1, 3'b010, 1);
    check("t4_b_out2", int'(b_out), 3);
    check("t4_dir2", int'(dir), 1);
    check("t4_err2", int'(step_err), 0);
    for (int i = 0; i < 5; i++) cycle(1, (i % 2 == 0) ? 3'b001 : 3'b010, 1);
    check("t4_sat", int'(s_err_cnt), 3);
    check("t4_cnt6", int'(err_cnt), 6);

    // Back-pressure: beat held, then drain and reload on the same edge.
    cycle(1, 3'b011, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 3'b111, 0);
      check("t5_hold", int'(b_out), 2);
    end
    cycle(1, 3'b111, 1);
    check("t5_reload", int'(b_out), 5);
    check("t5_valid", int'(b_valid), 1);

    // Reset between codes drops the pending beat; next code takes IDLE path.
    cycle(1, 3'b010, 0);
    do_reset();
    cycle(1, 3'b111, 1);
    check("t6_b_out", int'(b_out), 5);
    check("t6_err", int'(step_err), 0);

    // Randomized traffic: mostly legal steps, some repeats, some jumps.
    for (int n = 0; n < 2000; n++) begin
      int r, g;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)       g = m_prev_g ^ (1 << $urandom_range(0, W - 1));
        else if (r == 6) g = m_prev_g;
        else             g = $urandom_range(0, (1 << W) - 1);
        cycle($urandom_range(0, 3) != 0, g, $urandom_range(0, 3) != 0);
      end
    end
    cycle(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
